// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register-bank self-test sequencer.
// Holds the FSM state encoding and the write/readback pattern generator.
package reg_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    localparam int PAT_W = 32;

    // Pattern is seed XOR address; the second pass uses the bitwise inverse.
    function automatic logic [PAT_W-1:0] pattern_fn(
        input logic [PAT_W-1:0] seed,
        input logic [PAT_W-1:0] addr,
        input logic             inv
    );
        logic [PAT_W-1:0] p_s;
        p_s = seed ^ addr;
        if (inv) begin
            return ~p_s;
        end else begin
            return p_s;
        end
    endfunction

endpackage

// File: rtl/reg_bank_expected_pipe.sv
// Delay line carrying {valid, addr, expected} so each compare lines up with
// the bank's read data, which arrives DEPTH cycles after the read address.
module reg_bank_expected_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 12
) (
    input  logic             clock_signal,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift register, cleared synchronously.
    always_ff @(posedge clock_signal) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/reg_bank_self_test.sv
// Built-in self-test sequencer for the register bank: two write/readback passes
// (true then inverted pattern), reporting pass/fail, error count and first failing address.
module reg_bank_self_test
    import reg_bank_pkg::*;
#(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDR_WIDTH   = 3,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] SEED         = 32'h0000_00A5
) (
    input  logic                  clock_signal,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    localparam int                    ERR_W      = ADDR_WIDTH + 2;
    localparam int                    CW         = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int                    PIPE_W     = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
    localparam logic [CW-1:0]         DRAIN_LAST = CW'(READ_LATENCY - 1);

    bist_state_e           state_r, state_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  pass_sel_r, pass_sel_s;
    logic [CW-1:0]         drain_r, drain_s;

    logic                  busy_r, done_r, pass_r, wr_en_r;
    logic [ERR_W-1:0]      err_count_r, err_next_s;
    logic [ADDR_WIDTH-1:0] fail_addr_r, wr_addr_r, rd_addr_r;
    logic [DATA_WIDTH-1:0] wr_data_r;

    logic [PAT_W-1:0]      wr_pat_s, exp_pat_s;
    logic [PIPE_W-1:0]     pipe_in_s, pipe_out_s;
    logic                  pipe_valid_s, mismatch_s, start_acc_s;
    logic [ADDR_WIDTH-1:0] pipe_addr_s;
    logic [DATA_WIDTH-1:0] pipe_exp_s;

    // Next-state, address counter, pass select and drain counter.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        pass_sel_s = pass_sel_r;
        drain_s    = drain_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s    = ST_WR;
                    addr_s     = {ADDR_WIDTH{1'b0}};
                    pass_sel_s = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR: begin
                if (addr_r == ADDR_LAST) begin
                    state_s = ST_RD;
                    addr_s  = {ADDR_WIDTH{1'b0}};
                end else begin
                    addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_RD: begin
                if (addr_r == ADDR_LAST) begin
                    state_s = ST_DRAIN;
                    addr_s  = {ADDR_WIDTH{1'b0}};
                    drain_s = {CW{1'b0}};
                end else begin
                    addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    if (pass_sel_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s    = ST_WR;
                        pass_sel_s = 1'b1;
                    end
                end else begin
                    drain_s = drain_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign wr_pat_s  = pattern_fn(SEED, PAT_W'(addr_s), pass_sel_s);
    assign exp_pat_s = pattern_fn(SEED, PAT_W'(addr_r), pass_sel_r);
    assign pipe_in_s = {(state_r == ST_RD), addr_r, exp_pat_s[DATA_WIDTH-1:0]};

    reg_bank_expected_pipe #(
        .DEPTH (READ_LATENCY),
        .WIDTH (PIPE_W)
    ) u_expected_pipe (
        .clock_signal (clock_signal),
        .reset        (reset),
        .din          (pipe_in_s),
        .dout         (pipe_out_s)
    );

    assign pipe_valid_s = pipe_out_s[PIPE_W-1];
    assign pipe_addr_s  = pipe_out_s[PIPE_W-2 -: ADDR_WIDTH];
    assign pipe_exp_s   = pipe_out_s[DATA_WIDTH-1:0];
    assign mismatch_s   = pipe_valid_s && (rd_data != pipe_exp_s);
    assign start_acc_s  = (state_r == ST_IDLE) && start;
    assign err_next_s   = err_count_r + ERR_W'(mismatch_s);

    // Sequencer state and bank-port registers; outputs are loaded from next values so they align with state_r.
    always_ff @(posedge clock_signal) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= {ADDR_WIDTH{1'b0}};
            pass_sel_r <= 1'b0;
            drain_r    <= {CW{1'b0}};
            busy_r     <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            wr_data_r  <= {DATA_WIDTH{1'b0}};
            rd_addr_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            pass_sel_r <= pass_sel_s;
            drain_r    <= drain_s;
            busy_r     <= (state_s == ST_WR) || (state_s == ST_RD) || (state_s == ST_DRAIN);
            wr_en_r    <= (state_s == ST_WR);
            if (state_s == ST_WR) begin
                wr_addr_r <= addr_s;
                wr_data_r <= wr_pat_s[DATA_WIDTH-1:0];
            end
            if (state_s == ST_RD) begin
                rd_addr_r <= addr_s;
            end
        end
    end

    // Result registers: cleared on an accepted start, otherwise accumulate compares.
    always_ff @(posedge clock_signal) begin
        if (reset) begin
            err_count_r <= {ERR_W{1'b0}};
            fail_addr_r <= {ADDR_WIDTH{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else if (start_acc_s) begin
            err_count_r <= {ERR_W{1'b0}};
            fail_addr_r <= {ADDR_WIDTH{1'b0}};
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            err_count_r <= err_next_s;
            if (mismatch_s && (err_count_r == {ERR_W{1'b0}})) begin
                fail_addr_r <= pipe_addr_s;
            end
            // The final compare lands in the same edge that enters DONE, so judge on err_next_s.
            if (state_s == ST_DONE) begin
                done_r <= 1'b1;
                pass_r <= (err_next_s == {ERR_W{1'b0}});
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_count_r;
    assign fail_addr = fail_addr_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign rd_addr   = rd_addr_r;

endmodule

// File: tb/tb_reg_bank_self_test.sv
// Directed bench for reg_bank_self_test: a latency-1 instance with a fault-injecting
// bank model and a latency-3 instance with a clean bank model.
module tb_reg_bank_self_test;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start1, start3;
    logic       busy1, done1, pass1, wr_en1;
    logic [4:0] err1;
    logic [2:0] fail1, wr_addr1, rd_addr1;
    logic [7:0] wr_data1, rd_data1;
    logic       busy3, done3, pass3, wr_en3;
    logic [4:0] err3;
    logic [2:0] fail3, wr_addr3, rd_addr3;
    logic [7:0] wr_data3, rd_data3;

    logic [7:0] mem1 [8];
    logic [7:0] mem3 [8];
    logic [7:0] rd3_a, rd3_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int fault_mode   = 0;
    int cyc, nw;

    reg_bank_self_test #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(1), .SEED(32'h0000_00A5)) dut (
        .clock_signal(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_addr(fail1), .wr_en(wr_en1),
        .wr_addr(wr_addr1), .wr_data(wr_data1), .rd_addr(rd_addr1), .rd_data(rd_data1)
    );

    reg_bank_self_test #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .READ_LATENCY(3), .SEED(32'h0000_00A5)) dut3 (
        .clock_signal(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .fail_addr(fail3), .wr_en(wr_en3),
        .wr_addr(wr_addr3), .wr_data(wr_data3), .rd_addr(rd_addr3), .rd_data(rd_data3)
    );

    function automatic logic [7:0] bank_fault(input logic [2:0] a, input logic [7:0] d);
        if (fault_mode == 1 && a == 3'd5) begin
            return d & 8'hFE;
        end else if (fault_mode == 2 && a == 3'd2) begin
            return 8'h00;
        end else begin
            return d;
        end
    endfunction

    // Latency-1 bank with optional stuck-at faults applied on write.
    always @(posedge clk) begin
        if (wr_en1) mem1[wr_addr1] <= bank_fault(wr_addr1, wr_data1);
        rd_data1 <= mem1[rd_addr1];
    end

    // Clean latency-3 bank.
    always @(posedge clk) begin
        if (wr_en3) mem3[wr_addr3] <= wr_data3;
        rd3_a    <= mem3[rd_addr3];
        rd3_b    <= rd3_a;
        rd_data3 <= rd3_b;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse start on the latency-1 instance and count busy cycles; optionally re-pulse start at busy cycle 10.
    task automatic run1(input bit extra_start, output int n);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        check_val("done_cleared", {31'd0, done1}, 32'd0);
        n = 0;
        while (busy1 && n < 200) begin
            n++;
            start1 = (extra_start && n == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start1 = 1'b0;
    endtask

    task automatic check_result1(input string tag, input int n, input logic p, input logic [4:0] e, input logic [2:0] f);
        check_val({tag, "_busy_len"}, n, 32'd34);
        check_val({tag, "_done"}, {31'd0, done1}, 32'd1);
        check_val({tag, "_pass"}, {31'd0, pass1}, {31'd0, p});
        check_val({tag, "_err"}, {27'd0, err1}, {27'd0, e});
        check_val({tag, "_fail_addr"}, {29'd0, fail1}, {29'd0, f});
    endtask

    initial begin
        logic [7:0] exp_d;
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", {31'd0, busy1}, 32'd0);
        check_val("rst_done", {31'd0, done1}, 32'd0);
        check_val("rst_pass", {31'd0, pass1}, 32'd0);
        check_val("rst_err", {27'd0, err1}, 32'd0);
        check_val("rst_fail", {29'd0, fail1}, 32'd0);
        check_val("rst_wr_en", {31'd0, wr_en1}, 32'd0);
        check_val("rst_rd_addr", {29'd0, rd_addr1}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Scenario 1: clean bank.
        fault_mode = 0;
        run1(1'b0, cyc);
        check_result1("s1", cyc, 1'b1, 5'd0, 3'd0);
        repeat (3) @(negedge clk);
        check_val("s1_done_held", {31'd0, done1}, 32'd1);
        check_val("s1_wr_en_idle", {31'd0, wr_en1}, 32'd0);

        // Scenario 2: reg 5 bit0 stuck at 0; only pass 1 (8'h5F) is hit.
        fault_mode = 1;
        run1(1'b0, cyc);
        check_result1("s2", cyc, 1'b0, 5'd1, 3'd5);

        // Scenario 3: reg 2 stuck at 8'h00; both passes mismatch.
        fault_mode = 2;
        run1(1'b0, cyc);
        check_result1("s3", cyc, 1'b0, 5'd2, 3'd2);

        // Scenario 4: start re-pulsed while busy is ignored.
        fault_mode = 0;
        run1(1'b1, cyc);
        check_result1("s4", cyc, 1'b1, 5'd0, 3'd0);

        // Scenario 5: reset in pass-1 RD (busy cycle 27), after pass 0 already logged an error.
        fault_mode = 2;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (26) @(negedge clk);
        check_val("s5_busy_pre", {31'd0, busy1}, 32'd1);
        check_val("s5_err_pre", {27'd0, err1}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("s5_busy", {31'd0, busy1}, 32'd0);
        check_val("s5_done", {31'd0, done1}, 32'd0);
        check_val("s5_wr_en", {31'd0, wr_en1}, 32'd0);
        check_val("s5_err", {27'd0, err1}, 32'd0);
        check_val("s5_fail", {29'd0, fail1}, 32'd0);
        reset      = 1'b0;
        fault_mode = 0;
        @(negedge clk);
        run1(1'b0, cyc);
        check_result1("s5_rerun", cyc, 1'b1, 5'd0, 3'd0);

        // Scenario 6: read latency 3, with write address/data sequence checks.
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        cyc = 0;
        nw  = 0;
        while (busy3 && cyc < 200) begin
            if (wr_en3) begin
                exp_d = 8'hA5 ^ {5'd0, nw[2:0]};
                if (nw >= 8) exp_d = ~exp_d;
                check_val($sformatf("s6_wr_addr%0d", nw), {29'd0, wr_addr3}, {29'd0, nw[2:0]});
                check_val($sformatf("s6_wr_data%0d", nw), {24'd0, wr_data3}, {24'd0, exp_d});
                nw++;
            end
            cyc++;
            @(negedge clk);
        end
        check_val("s6_busy_len", cyc, 32'd38);
        check_val("s6_writes", nw, 32'd16);
        check_val("s6_done", {31'd0, done3}, 32'd1);
        check_val("s6_pass", {31'd0, pass3}, 32'd1);
        check_val("s6_err", {27'd0, err3}, 32'd0);
        check_val("s6_fail", {29'd0, fail3}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
